// File: rtl/edge_crop.sv
// Edge-magnitude crop stage: drops window-fill border, thresholds and saturates.
// Optional macro EDGE_CROP_BINARY_EN selects a binary edge map output.
`timescale 1ns/1ps
module edge_crop #(
  parameter int linewidth_px_p = 16,
  parameter int height_px_p    = 16,
  parameter int in_width_p     = 32,
  parameter int out_width_p    = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [in_width_p-1:0]  data_i,
  input  logic [in_width_p-1:0]  threshold_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [out_width_p-1:0] data_o,
  output logic                   eol_o,
  output logic                   eof_o
);

  localparam int CW = $clog2(linewidth_px_p);
  localparam int RW = $clog2(height_px_p);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  accept;
  logic                  keep;
  logic                  last_col;
  logic                  last_row;
  logic [in_width_p:0]   ext;
  logic [in_width_p:0]   mag;
  logic                  below;
  logic                  sat;
  logic [out_width_p-1:0] pix;

  assign ready_o  = ~valid_o | ready_i;
  assign accept   = valid_i & ready_o;
  assign last_col = col == CW'(linewidth_px_p - 1);
  assign last_row = row == RW'(height_px_p - 1);
  assign keep     = (col >= CW'(2)) && (row >= RW'(2));

  // One extra bit so the most-negative sample has a representable magnitude
  assign ext   = {data_i[in_width_p-1], data_i};
  assign mag   = data_i[in_width_p-1] ? (~ext + (in_width_p+1)'(1)) : ext;
  assign below = mag < {1'b0, threshold_i};
  assign sat   = |mag[in_width_p:out_width_p];

  always_comb begin
    pix = '0;
`ifdef EDGE_CROP_BINARY_EN
    if (!below) pix = '1;
`else
    if (!below) pix = sat ? '1 : mag[out_width_p-1:0];
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      eol_o   <= 1'b0;
      eof_o   <= 1'b0;
    end else if (ready_o) begin
      valid_o <= accept & keep;
      data_o  <= (accept & keep) ? pix : '0;
      eol_o   <= accept & keep & last_col;
      eof_o   <= accept & keep & last_col & last_row;
    end
  end

endmodule
